// File: rtl/episode_scheduler.sv
// Episode/step sequencer for a Q-learning training run: launches agent steps,
// requests Q-table updates and tracks episode boundaries with a free-running LFSR.
module episode_scheduler #(
    parameter int          STATES_WIDTH  = 4,
    parameter int          ACTIONS_WIDTH = 2,
    parameter int          COUNTER_WIDTH = 16,
    parameter int          MAX_STEPS     = 64,
    parameter int          MAX_EPISODES  = 1000,
    parameter int          GOAL_STATE    = 15,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_agent_valid,
    input  logic [STATES_WIDTH-1:0]  i_next_st,
    input  logic                     i_q_done,
    output logic                     o_agent_valid,
    output logic [COUNTER_WIDTH-1:0] o_count,
    output logic [COUNTER_WIDTH-1:0] o_step,
    output logic [STATES_WIDTH-1:0]  o_first_st,
    output logic [ACTIONS_WIDTH-1:0] o_at_random,
    output logic                     o_q_update,
    output logic                     o_busy,
    output logic                     o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_AGENT,
        S_UPDATE,
        S_WAIT_Q,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] LAST_STEP    = COUNTER_WIDTH'(MAX_STEPS - 1);
    localparam logic [COUNTER_WIDTH-1:0] LAST_EPISODE = COUNTER_WIDTH'(MAX_EPISODES - 1);
    localparam logic [STATES_WIDTH-1:0]  GOAL         = STATES_WIDTH'(GOAL_STATE);
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0]              LFSR_TAPS    = 16'hB400;

    state_t                    state_reg;
    logic [15:0]               lfsr_reg;
    logic [15:0]               lfsr_next;
    logic [COUNTER_WIDTH-1:0]  count_reg;
    logic [COUNTER_WIDTH-1:0]  step_reg;
    logic [STATES_WIDTH-1:0]   first_st_reg;
    logic [STATES_WIDTH-1:0]   next_st_reg;
    logic                      agent_valid_reg;
    logic                      q_update_reg;
    logic                      busy_reg;
    logic                      done_reg;
    logic                      episode_end;
    logic                      last_episode;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr
            if (gi == 15) begin : g_msb
                assign lfsr_next[gi] = LFSR_TAPS[gi] & lfsr_reg[0];
            end else begin : g_bit
                assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_TAPS[gi] & lfsr_reg[0]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    // Goal and step limit together still close a single episode.
    assign episode_end  = (next_st_reg == GOAL) || (step_reg == LAST_STEP);
    assign last_episode = (count_reg == LAST_EPISODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            count_reg       <= '0;
            step_reg        <= '0;
            first_st_reg    <= '0;
            next_st_reg     <= '0;
            agent_valid_reg <= 1'b0;
            q_update_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        count_reg       <= '0;
                        step_reg        <= '0;
                        first_st_reg    <= lfsr_reg[15 -: STATES_WIDTH];
                        agent_valid_reg <= 1'b1;
                        busy_reg        <= 1'b1;
                        state_reg       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    agent_valid_reg <= 1'b0;
                    state_reg       <= S_WAIT_AGENT;
                end
                S_WAIT_AGENT: begin
                    if (i_agent_valid) begin
                        next_st_reg  <= i_next_st;
                        q_update_reg <= 1'b1;
                        state_reg    <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    q_update_reg <= 1'b0;
                    state_reg    <= S_WAIT_Q;
                end
                S_WAIT_Q: begin
                    if (i_q_done) begin
                        state_reg <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (!episode_end) begin
                        step_reg        <= step_reg + 1'b1;
                        agent_valid_reg <= 1'b1;
                        state_reg       <= S_ISSUE;
                    end else if (last_episode) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        count_reg       <= count_reg + 1'b1;
                        step_reg        <= '0;
                        first_st_reg    <= lfsr_reg[15 -: STATES_WIDTH];
                        agent_valid_reg <= 1'b1;
                        state_reg       <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    // A start level left high from the finished run must not relaunch it.
                    if (!i_start) begin
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    agent_valid_reg <= 1'b0;
                    q_update_reg    <= 1'b0;
                    busy_reg        <= 1'b0;
                    done_reg        <= 1'b0;
                    state_reg       <= S_IDLE;
                end
            endcase
        end
    end

    assign o_agent_valid = agent_valid_reg;
    assign o_count       = count_reg;
    assign o_step        = step_reg;
    assign o_first_st    = first_st_reg;
    assign o_at_random   = lfsr_reg[ACTIONS_WIDTH-1:0];
    assign o_q_update    = q_update_reg;
    assign o_busy        = busy_reg;
    assign o_done        = done_reg;

endmodule

// File: tb/tb_episode_scheduler.sv
// Directed bench for episode_scheduler: scoreboard of expected (episode, step)
// per agent launch, plus a reference LFSR for the random action output.
module tb_episode_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic        i_agent_valid;
    logic [3:0]  i_next_st;
    logic        i_q_done;
    logic        o_agent_valid;
    logic [15:0] o_count;
    logic [15:0] o_step;
    logic [3:0]  o_first_st;
    logic [1:0]  o_at_random;
    logic        o_q_update;
    logic        o_busy;
    logic        o_done;

    episode_scheduler #(
        .STATES_WIDTH (4),
        .ACTIONS_WIDTH(2),
        .COUNTER_WIDTH(16),
        .MAX_STEPS    (4),
        .MAX_EPISODES (2),
        .GOAL_STATE   (5),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_agent_valid(i_agent_valid),
        .i_next_st    (i_next_st),
        .i_q_done     (i_q_done),
        .o_agent_valid(o_agent_valid),
        .o_count      (o_count),
        .o_step       (o_step),
        .o_first_st   (o_first_st),
        .o_at_random  (o_at_random),
        .o_q_update   (o_q_update),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        int step;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_pulse;
    int          exp_count;
    int          exp_step;
    bit          exp_done;
    logic [3:0]  exp_first;
    logic [15:0] model_lfsr;
    logic [15:0] model_prev;
    logic [1:0]  rec_a[8];
    logic [1:0]  rec_b[8];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference generator: shift right, feed the output bit back into 15,13,12,10.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_lfsr <= 16'hACE1;
            model_prev <= 16'hACE1;
        end else begin
            model_prev <= model_lfsr;
            model_lfsr <= {model_lfsr[0], model_lfsr[15:1]} ^ ({16{model_lfsr[0]}} & 16'h3400);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("at_random", 32'(o_at_random), 32'(model_lfsr[1:0]));
    endtask

    task automatic start_run(input bit hold);
        exp_count  = 0;
        exp_step   = 0;
        exp_done   = 1'b0;
        last_pulse = -1;
        sb.push_back('{0, 0});
        i_start = 1'b1;
        tick();
        if (!hold) i_start = 1'b0;
    endtask

    // One agent step: adly extra WAIT_AGENT cycles, nst returned as next state.
    task automatic do_step(input int adly, input logic [3:0] nst, input bit q_held);
        int   waited = 0;
        exp_t e;
        bit   ended;
        while (!o_agent_valid && waited < 40) begin
            tick();
            waited++;
        end
        check("pulse_timeout", 32'(o_agent_valid), 32'd1);
        if (!o_agent_valid) return;
        check("sb_pulse_expected", 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        $display("step: count=%0d step=%0d first_st=%0d nst=%0d adly=%0d", o_count, o_step, o_first_st, nst, adly);
        check("count", 32'(o_count), 32'(e.count));
        check("step", 32'(o_step), 32'(e.step));
        if (e.step == 0) exp_first = model_prev[15:12];
        check("first_st", 32'(o_first_st), 32'(exp_first));
        if (last_pulse >= 0) check("pulse_spacing", 32'(cyc - last_pulse), 32'd5);
        last_pulse = (adly == 0) ? cyc : -1;
        tick();
        check("agent_valid_width", 32'(o_agent_valid), 32'd0);
        repeat (adly) tick();
        i_agent_valid = 1'b1;
        i_next_st     = nst;
        tick();
        i_agent_valid = 1'b0;
        check("q_update_pulse", 32'(o_q_update), 32'd1);
        ended = (nst == 4'd5) || (exp_step == 3);
        if (!ended) begin
            exp_step++;
            sb.push_back('{exp_count, exp_step});
        end else if (exp_count == 1) begin
            exp_done = 1'b1;
        end else begin
            exp_count++;
            exp_step = 0;
            sb.push_back('{exp_count, exp_step});
        end
        tick();
        check("q_update_width", 32'(o_q_update), 32'd0);
        if (!q_held) i_q_done = 1'b1;
        tick();
        if (!q_held) i_q_done = 1'b0;
        check("busy_in_next", 32'(o_busy), 32'd1);
        tick();
        if (exp_done) begin
            check("done_set", 32'(o_done), 32'd1);
            check("done_busy", 32'(o_busy), 32'd0);
            check("done_no_pulse", 32'(o_agent_valid), 32'd0);
            check("done_count", 32'(o_count), 32'(exp_count));
            check("done_step", 32'(o_step), 32'(exp_step));
        end else begin
            check("next_issue", 32'(o_agent_valid), 32'd1);
        end
    endtask

    initial begin
        int pulses;
        rst_n         = 1'b0;
        i_start       = 1'b0;
        i_agent_valid = 1'b0;
        i_next_st     = '0;
        i_q_done      = 1'b0;
        exp_first     = '0;
        tick();
        tick();
        check("rst_agent_valid", 32'(o_agent_valid), 32'd0);
        check("rst_q_update", 32'(o_q_update), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_step", 32'(o_step), 32'd0);
        check("rst_first_st", 32'(o_first_st), 32'd0);
        check("rst_at_random", 32'(o_at_random), 32'd1);
        rst_n = 1'b1;
        rec_a[0] = o_at_random;
        for (int i = 1; i < 8; i++) begin
            tick();
            rec_a[i] = o_at_random;
        end

        // Full run, no goal reached: 2 episodes x 4 steps at minimum latency.
        start_run(1'b0);
        for (int i = 0; i < 8; i++) do_step(0, 4'd0, 1'b0);
        tick();
        check("done_to_idle", 32'(o_done), 32'd0);
        check("idle_busy", 32'(o_busy), 32'd0);

        // Goal at step 1 ends episode 0 early; start pulse while busy ignored.
        start_run(1'b0);
        do_step(0, 4'd0, 1'b0);
        do_step(0, 4'd5, 1'b0);
        do_step(0, 4'd0, 1'b0);
        i_start = 1'b1;
        do_step(0, 4'd0, 1'b0);
        i_start = 1'b0;
        do_step(0, 4'd0, 1'b0);
        do_step(0, 4'd5, 1'b0);
        tick();
        check("run2_idle", 32'(o_done), 32'd0);

        // Start held high all run; goal and step limit coincide; slow agent with q_done stuck high.
        start_run(1'b1);
        do_step(0, 4'd0, 1'b0);
        do_step(0, 4'd0, 1'b0);
        do_step(0, 4'd0, 1'b0);
        do_step(0, 4'd5, 1'b0);
        i_q_done = 1'b1;
        do_step(10, 4'd0, 1'b1);
        i_q_done = 1'b0;
        do_step(0, 4'd0, 1'b0);
        do_step(0, 4'd0, 1'b0);
        do_step(0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("done_hold", 32'(o_done), 32'd1);
        end
        i_start = 1'b0;
        tick();
        check("held_done_release", 32'(o_done), 32'd0);
        tick();
        check("held_idle_busy", 32'(o_busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Reset asserted while waiting for the Q update.
        start_run(1'b0);
        tick();
        i_agent_valid = 1'b1;
        i_next_st     = 4'd2;
        tick();
        i_agent_valid = 1'b0;
        tick();
        check("pre_rst_busy", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_q_update", 32'(o_q_update), 32'd0);
        check("arst_agent_valid", 32'(o_agent_valid), 32'd0);
        check("arst_done", 32'(o_done), 32'd0);
        check("arst_count", 32'(o_count), 32'd0);
        check("arst_step", 32'(o_step), 32'd0);
        check("arst_first_st", 32'(o_first_st), 32'd0);
        check("arst_at_random", 32'(o_at_random), 32'd1);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        rec_b[0] = o_at_random;
        for (int i = 1; i < 8; i++) begin
            tick();
            rec_b[i] = o_at_random;
        end
        for (int i = 0; i < 8; i++) check("rand_repeat", 32'(rec_b[i]), 32'(rec_a[i]));
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_agent_valid || o_q_update || o_busy) pulses++;
        end
        check("post_rst_quiet", 32'(pulses), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
